init_deal_ctrl: RTL and testbench
=================================

INIT_DEAL_CTRL -- requirements
Module: init_deal_ctrl

Interface
REQ-001 The block SHALL have parameter PLAYER, default 0, meaning this board's player index (0 or 1).
REQ-002 The block SHALL have parameter TOTAL_DRAWS, default 28, meaning the number of initial draws across both players.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start_game, input, 1 bit: a one-cycle pulse that begins the deal.
REQ-006 The block SHALL have port available_card, input, 106 bits: bit i = 1 means deck card i can be drawn.
REQ-007 The block SHALL have port draw_ack, input, 1 bit: a one-cycle pulse from interboard/memory confirming the issued draw was committed.
REQ-008 The block SHALL have port peer_draw, input, 1 bit: a one-cycle pulse meaning the opponent's draw was committed.
REQ-009 The block SHALL have port deal_en, output, 1 bit: a one-cycle draw request.
REQ-010 The block SHALL have port deal_card, output, 7 bits: the card index 0..105, valid while deal_en=1.
REQ-011 The block SHALL have port deal_msg_type, output, 4 bits: constant 6 (DECK_DRAW).
REQ-012 The block SHALL have port deal_count, output, 5 bits: draws completed, 0..TOTAL_DRAWS.
REQ-013 The block SHALL have port my_init_turn, output, 1 bit: high while the current draw belongs to this player.
REQ-014 The block SHALL have port deal_busy, output, 1 bit: high in any state other than IDLE, DONE or ERR.
REQ-015 The block SHALL have port deal_done, output, 1 bit: a level, high in DONE.
REQ-016 The block SHALL have port deal_error, output, 1 bit: a level, high in ERR (no available card).

Function
REQ-017 The block SHALL implement states IDLE, TURN, SEARCH, ISSUE, WAIT_ACK, DONE and ERR.
REQ-018 IDLE SHALL move to TURN on start_game, clearing deal_count to 0; start_game SHALL be ignored in every other state except DONE and ERR, where it restarts exactly as from IDLE.
REQ-019 TURN SHALL go to DONE if deal_count==TOTAL_DRAWS; otherwise to SEARCH if deal_count[0]==PLAYER, else wait there.
REQ-020 my_init_turn SHALL equal (deal_count[0]==PLAYER) && state is TURN, SEARCH, ISSUE or WAIT_ACK.
REQ-021 In TURN during the opponent's turn, a peer_draw pulse SHALL increment deal_count by 1 and re-evaluate next cycle; peer_draw SHALL be ignored during this player's turn and in IDLE, DONE and ERR.
REQ-022 The block SHALL run a 7-bit Fibonacci LFSR, taps x^7+x^6+1, reset seed 7'h5A, advancing every cycle out of reset in all states.
REQ-023 On entering SEARCH, the scan pointer SHALL load lfsr if lfsr<106, else lfsr-106.
REQ-024 SEARCH SHALL examine one bit per cycle: if available_card[ptr]==1, latch ptr into deal_card and go to ISSUE; otherwise increment ptr, wrapping 105->0.
REQ-025 SEARCH SHALL go to ERR after 106 consecutive misses.
REQ-026 ISSUE SHALL assert deal_en for exactly one cycle, then go to WAIT_ACK.
REQ-027 deal_card SHALL hold stable from ISSUE until the next ISSUE.
REQ-028 WAIT_ACK SHALL, on draw_ack, increment deal_count and return to TURN; there is no timeout.
REQ-029 A draw_ack outside WAIT_ACK SHALL be ignored.
REQ-030 deal_count SHALL never exceed TOTAL_DRAWS; an increment request at TOTAL_DRAWS SHALL be dropped.
REQ-031 If draw_ack and peer_draw arrive in the same cycle, only the pulse relevant to the current state SHALL take effect.
REQ-032 available_card SHALL be sampled live each SEARCH cycle, and the block SHALL NOT modify it.
REQ-033 Per deal: 14 draws SHALL be issued by this board and 14 counted from the peer, with player 0 drawing first (draw 0).

Reset
REQ-034 When rst=0, asynchronously: state=IDLE, deal_count=0, deal_card=0, lfsr=7'h5A, deal_en=0, my_init_turn=0, deal_busy=0, deal_done=0, deal_error=0; deal_msg_type stays 6.
REQ-035 Reset mid-deal SHALL abandon the deal with no further deal_en; a fresh start_game is required after release.
REQ-036 An outstanding draw_ack arriving after reset release SHALL be ignored, since the block is in IDLE.

Verification
REQ-037 Scenario 1: PLAYER=0, all 106 available, start_game, ack each deal_en 3 cycles later, peer_draw 5 cycles after each ack -> 14 deal_en pulses, deal_count reaches 28, deal_done=1, no deal_en afterwards.
REQ-038 Scenario 2: PLAYER=1, start_game, no peer_draw -> deal_en stays 0 and my_init_turn stays 0 indefinitely; one peer_draw -> deal_en within 110 cycles.
REQ-039 Scenario 3: only available_card[3]=1, forced scan start 100 -> ptr wraps 105->0, deal_card=3 after 10 SEARCH cycles.
REQ-040 Scenario 4: available_card all 0 on this player's turn -> deal_error=1 after 106 SEARCH cycles, deal_en never asserted; start_game -> deal_count=0, deal_busy=1.
REQ-041 Scenario 5: rst low while in WAIT_ACK with deal_count=7 -> all outputs at reset values immediately, asynchronously; post-release draw_ack ignored, deal_count stays 0.
REQ-042 Scenario 6: draw_ack and peer_draw pulsed together in WAIT_ACK -> deal_count increments by exactly 1.

Source files
------------

// File: rtl/init_deal_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// init_deal_ctrl : alternating initial-deal draw sequencer for one board
// Rev 1.0
// ---------------------------------------------------------------------------
module init_deal_ctrl #(
  parameter int PLAYER      = 0,
  parameter int TOTAL_DRAWS = 28
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_game,
  input  logic [105:0] available_card,
  input  logic         draw_ack,
  input  logic         peer_draw,
  output logic         deal_en,
  output logic [6:0]   deal_card,
  output logic [3:0]   deal_msg_type,
  output logic [4:0]   deal_count,
  output logic         my_init_turn,
  output logic         deal_busy,
  output logic         deal_done,
  output logic         deal_error
);

  localparam logic [6:0] c_num_cards = 7'd106;
  localparam logic [6:0] c_last_card = 7'd105;
  localparam logic [6:0] c_lfsr_seed = 7'h5A;
  localparam logic [4:0] c_total     = 5'(TOTAL_DRAWS);
  localparam logic       c_player    = 1'(PLAYER);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_TURN     = 3'd1,
    S_SEARCH   = 3'd2,
    S_ISSUE    = 3'd3,
    S_WAIT_ACK = 3'd4,
    S_DONE     = 3'd5,
    S_ERR      = 3'd6
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] count_q, count_d;
  logic [6:0] card_q, card_d;
  logic [6:0] lfsr_q, lfsr_d;
  logic [6:0] ptr_q, ptr_d;
  logic [6:0] miss_q, miss_d;
  logic       deal_en_q, deal_en_d;
  logic       my_turn_q, my_turn_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       w_own_turn;
  logic       w_can_inc;
  logic       w_active_d;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    card_d     = card_q;
    ptr_d      = ptr_q;
    miss_d     = miss_q;
    lfsr_d     = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
    w_own_turn = (count_q[0] == c_player);
    w_can_inc  = (count_q < c_total);

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_game) begin
          state_d = S_TURN;
          count_d = 5'd0;
        end
      end
      S_TURN: begin
        if (count_q >= c_total) begin
          state_d = S_DONE;
        end else if (w_own_turn) begin
          state_d = S_SEARCH;
          miss_d  = 7'd0;
          // Fold the 7-bit random value into the 0..105 card range.
          ptr_d   = (lfsr_q < c_num_cards) ? lfsr_q : (lfsr_q - c_num_cards);
        end else if (peer_draw && w_can_inc) begin
          count_d = count_q + 5'd1;
        end
      end
      S_SEARCH: begin
        if (available_card[ptr_q]) begin
          card_d  = ptr_q;
          state_d = S_ISSUE;
        end else if (miss_q == c_last_card) begin
          state_d = S_ERR;
        end else begin
          miss_d = miss_q + 7'd1;
          ptr_d  = (ptr_q == c_last_card) ? 7'd0 : (ptr_q + 7'd1);
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (draw_ack) begin
          state_d = S_TURN;
          if (w_can_inc) begin
            count_d = count_q + 5'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    w_active_d = (state_d == S_TURN) || (state_d == S_SEARCH) ||
                 (state_d == S_ISSUE) || (state_d == S_WAIT_ACK);
    deal_en_d  = (state_d == S_ISSUE);
    my_turn_d  = w_active_d && (count_d[0] == c_player);
    busy_d     = w_active_d;
    done_d     = (state_d == S_DONE);
    err_d      = (state_d == S_ERR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      count_q   <= 5'd0;
      card_q    <= 7'd0;
      lfsr_q    <= c_lfsr_seed;
      ptr_q     <= 7'd0;
      miss_q    <= 7'd0;
      deal_en_q <= 1'b0;
      my_turn_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      card_q    <= card_d;
      lfsr_q    <= lfsr_d;
      ptr_q     <= ptr_d;
      miss_q    <= miss_d;
      deal_en_q <= deal_en_d;
      my_turn_q <= my_turn_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign deal_en       = deal_en_q;
  assign deal_card     = card_q;
  assign deal_msg_type = 4'd6;
  assign deal_count    = count_q;
  assign my_init_turn  = my_turn_q;
  assign deal_busy     = busy_q;
  assign deal_done     = done_q;
  assign deal_error    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_init_deal_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_init_deal_ctrl : randomized self-checking bench for init_deal_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_init_deal_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_game = 1'b0, draw_ack = 1'b0, peer_draw = 1'b0;
  logic         start1 = 1'b0, ack1 = 1'b0, peer1 = 1'b0;
  logic [105:0] available_card = '0;

  logic         deal_en0, my_turn0, busy0, done0, err0;
  logic [6:0]   deal_card0;
  logic [3:0]   msg0;
  logic [4:0]   deal_count0;
  logic         deal_en1, my_turn1, busy1, done1, err1;
  logic [6:0]   deal_card1;
  logic [3:0]   msg1;
  logic [4:0]   deal_count1;

  int          checks = 0;
  int          errors = 0;
  int          cyc;
  logic [6:0]  seq [127];

  localparam logic [20:0] c_rst_vec = {1'b0, 7'd0, 4'd6, 5'd0, 4'b0000};

  init_deal_ctrl #(.PLAYER(0), .TOTAL_DRAWS(28)) u_p0 (
    .clk(clk), .rst(rst), .start_game(start_game), .available_card(available_card),
    .draw_ack(draw_ack), .peer_draw(peer_draw), .deal_en(deal_en0), .deal_card(deal_card0),
    .deal_msg_type(msg0), .deal_count(deal_count0), .my_init_turn(my_turn0),
    .deal_busy(busy0), .deal_done(done0), .deal_error(err0)
  );

  init_deal_ctrl #(.PLAYER(1), .TOTAL_DRAWS(28)) u_p1 (
    .clk(clk), .rst(rst), .start_game(start1), .available_card(available_card),
    .draw_ack(ack1), .peer_draw(peer1), .deal_en(deal_en1), .deal_card(deal_card1),
    .deal_msg_type(msg1), .deal_count(deal_count1), .my_init_turn(my_turn1),
    .deal_busy(busy1), .deal_done(done1), .deal_error(err1)
  );

  always #5 clk = ~clk;

  // Edges since reset release; the design's random source has taken exactly this many steps.
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  function automatic logic en_of(input bit i);
    return i ? deal_en1 : deal_en0;
  endfunction
  function automatic logic [6:0] card_of(input bit i);
    return i ? deal_card1 : deal_card0;
  endfunction
  function automatic logic turn_of(input bit i);
    return i ? my_turn1 : my_turn0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    tick();
    rst = 1'b1;
  endtask

  task automatic pulse(input bit inst, input bit st, input bit ack, input bit peer, output int trig);
    if (inst) begin start1 = st; ack1 = ack; peer1 = peer; end
    else begin start_game = st; draw_ack = ack; peer_draw = peer; end
    tick();
    start_game = 1'b0; draw_ack = 1'b0; peer_draw = 1'b0;
    start1 = 1'b0; ack1 = 1'b0; peer1 = 1'b0;
    trig = cyc;
  endtask

  function automatic logic [105:0] rand_avail();
    logic [105:0] v;
    v = '0;
    for (int i = 0; i < 106; i++) v[i] = ($urandom_range(0, 7) == 0);
    v[$urandom_range(0, 105)] = 1'b1;
    return v;
  endfunction

  // Reference: scan starts at the random value seen on the triggering edge, folded into
  // 0..105, and walks upward with wrap; the first hit is issued one cycle after
  // examination j, and 106 misses end in the error state.
  function automatic void predict(input logic [105:0] av, input int trig,
                                  output int card, output int ev_cyc, output bit hit);
    int start;
    start  = int'(seq[trig % 127]);
    if (start >= 106) start -= 106;
    hit    = 1'b0;
    card   = 0;
    ev_cyc = trig + 107;
    for (int j = 0; j < 106; j++) begin
      if (!hit && av[(start + j) % 106]) begin
        hit    = 1'b1;
        card   = (start + j) % 106;
        ev_cyc = trig + 2 + j;
      end
    end
  endfunction

  task automatic expect_draw(input bit inst, input int trig, input string tag);
    int  card, ecyc, waited;
    bit  hit;
    predict(available_card, trig, card, ecyc, hit);
    waited = 0;
    while (!en_of(inst) && waited < 300) begin
      tick();
      waited++;
    end
    checks++;
    if (!en_of(inst)) begin
      errors++;
      $display("FAIL %s_timeout: deal_en not seen, expected at cycle %0d", tag, ecyc);
    end else begin
      if (cyc != ecyc) begin
        errors++;
        $display("FAIL %s_timing: deal_en at cycle %0d, expected %0d", tag, cyc, ecyc);
      end
      checks++;
      if (card_of(inst) !== 7'(card)) begin
        errors++;
        $display("FAIL %s_card: got %0d, expected %0d", tag, card_of(inst), card);
      end
      checks++;
      if (turn_of(inst) !== 1'b1) begin
        errors++;
        $display("FAIL %s_my_turn: got %b, expected 1", tag, turn_of(inst));
      end
      tick();
      checks++;
      if (en_of(inst) !== 1'b0 || card_of(inst) !== 7'(card)) begin
        errors++;
        $display("FAIL %s_one_cycle: deal_en=%b card=%0d, expected 0 / %0d", tag,
                 en_of(inst), card_of(inst), card);
      end
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #2;
    checks++;
    if ({deal_en0, deal_card0, msg0, deal_count0, my_turn0, busy0, done0, err0} !== c_rst_vec) begin
      errors++;
      $display("FAIL reset_values: got %h, expected %h",
               {deal_en0, deal_card0, msg0, deal_count0, my_turn0, busy0, done0, err0}, c_rst_vec);
    end
    tick();
    tick();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (busy0 !== 1'b0 || deal_count0 !== 5'd0 || deal_en0 !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy0=%b count0=%0d en0=%b busy1=%b, expected 0/0/0/0",
               busy0, deal_count0, deal_en0, busy1);
    end
  endtask

  task automatic test_full_deal();
    int trig;
    bit stray;
    do_reset();
    available_card = rand_avail();
    pulse(0, 1, 0, 0, trig);
    for (int d = 0; d < 14; d++) begin
      expect_draw(0, trig, "full_deal");
      checks++;
      if (deal_count0 !== 5'(2 * d)) begin
        errors++;
        $display("FAIL full_deal_count_draw: got %0d, expected %0d", deal_count0, 2 * d);
      end
      tick();
      pulse(0, 0, 1, 0, trig);
      checks++;
      if (deal_count0 !== 5'(2 * d + 1) || my_turn0 !== 1'b0) begin
        errors++;
        $display("FAIL full_deal_after_ack: count=%0d my_turn=%b, expected %0d / 0",
                 deal_count0, my_turn0, 2 * d + 1);
      end
      repeat (4) tick();
      available_card = rand_avail();
      pulse(0, 0, 0, 1, trig);
      checks++;
      if (deal_count0 !== 5'(2 * d + 2) || my_turn0 !== 1'b1) begin
        errors++;
        $display("FAIL full_deal_after_peer: count=%0d my_turn=%b, expected %0d / 1",
                 deal_count0, my_turn0, 2 * d + 2);
      end
    end
    tick();
    checks++;
    if (done0 !== 1'b1 || busy0 !== 1'b0 || deal_count0 !== 5'd28 || my_turn0 !== 1'b0) begin
      errors++;
      $display("FAIL full_deal_done: done=%b busy=%b count=%0d my_turn=%b, expected 1/0/28/0",
               done0, busy0, deal_count0, my_turn0);
    end
    stray = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (k == 10) pulse(0, 0, 0, 1, trig);
      else if (k == 20) pulse(0, 0, 1, 0, trig);
      else tick();
      if (deal_en0) stray = 1'b1;
    end
    checks++;
    if (stray || deal_count0 !== 5'd28 || done0 !== 1'b1) begin
      errors++;
      $display("FAIL full_deal_hold: stray_en=%b count=%0d done=%b, expected 0/28/1",
               stray, deal_count0, done0);
    end
  endtask

  task automatic test_wrap();
    int trig;
    do_reset();
    available_card = '0;
    available_card[3] = 1'b1;
    for (int k = 0; k < 200 && seq[(cyc + 1) % 127] != 7'd100; k++) tick();
    pulse(0, 1, 0, 0, trig);
    checks++;
    if (seq[trig % 127] != 7'd100) begin
      errors++;
      $display("FAIL wrap_setup: scan start %0d, expected 100", seq[trig % 127]);
    end
    expect_draw(0, trig, "wrap");
  endtask

  task automatic test_pulse_filter();
    int trig, dummy;
    do_reset();
    available_card = rand_avail();
    pulse(0, 1, 0, 0, trig);
    expect_draw(0, trig, "filter_first");
    pulse(0, 0, 0, 1, dummy);
    checks++;
    if (deal_count0 !== 5'd0 || busy0 !== 1'b1 || my_turn0 !== 1'b1) begin
      errors++;
      $display("FAIL filter_peer_own_turn: count=%0d busy=%b my_turn=%b, expected 0/1/1",
               deal_count0, busy0, my_turn0);
    end
    pulse(0, 0, 1, 1, dummy);
    checks++;
    if (deal_count0 !== 5'd1) begin
      errors++;
      $display("FAIL filter_ack_and_peer: count=%0d, expected 1", deal_count0);
    end
    pulse(0, 0, 1, 0, dummy);
    checks++;
    if (deal_count0 !== 5'd1 || my_turn0 !== 1'b0) begin
      errors++;
      $display("FAIL filter_stray_ack: count=%0d my_turn=%b, expected 1/0", deal_count0, my_turn0);
    end
    available_card = rand_avail();
    pulse(0, 0, 0, 1, trig);
    pulse(0, 1, 0, 0, dummy);
    expect_draw(0, trig, "filter_second");
    checks++;
    if (deal_count0 !== 5'd2) begin
      errors++;
      $display("FAIL filter_start_ignored: count=%0d, expected 2", deal_count0);
    end
  endtask

  task automatic test_error();
    int  trig, waited;
    bit  stray;
    do_reset();
    available_card = rand_avail();
    pulse(0, 1, 0, 0, trig);
    expect_draw(0, trig, "error_pre");
    pulse(0, 0, 1, 0, trig);
    available_card = '0;
    pulse(0, 0, 0, 1, trig);
    waited = 0;
    stray  = 1'b0;
    while (!err0 && waited < 300) begin
      tick();
      waited++;
      if (deal_en0) stray = 1'b1;
    end
    checks++;
    if (err0 !== 1'b1 || cyc != trig + 107) begin
      errors++;
      $display("FAIL error_timing: deal_error=%b at cycle %0d, expected 1 at %0d",
               err0, cyc, trig + 107);
    end
    checks++;
    if (stray || busy0 !== 1'b0 || deal_count0 !== 5'd2 || done0 !== 1'b0) begin
      errors++;
      $display("FAIL error_state: stray_en=%b busy=%b count=%0d done=%b, expected 0/0/2/0",
               stray, busy0, deal_count0, done0);
    end
    pulse(0, 1, 0, 0, trig);
    checks++;
    if (deal_count0 !== 5'd0 || busy0 !== 1'b1 || err0 !== 1'b0) begin
      errors++;
      $display("FAIL error_restart: count=%0d busy=%b error=%b, expected 0/1/0",
               deal_count0, busy0, err0);
    end
  endtask

  task automatic test_player1_and_reset();
    int  trig, dummy;
    bit  stray_en, stray_turn;
    do_reset();
    pulse(1, 1, 0, 0, trig);
    stray_en = 1'b0;
    stray_turn = 1'b0;
    for (int k = 0; k < 150; k++) begin
      tick();
      if (deal_en1) stray_en = 1'b1;
      if (my_turn1) stray_turn = 1'b1;
    end
    checks++;
    if (stray_en || stray_turn || busy1 !== 1'b1 || deal_count1 !== 5'd0) begin
      errors++;
      $display("FAIL p1_waits: en=%b my_turn=%b busy=%b count=%0d, expected 0/0/1/0",
               stray_en, stray_turn, busy1, deal_count1);
    end
    available_card = rand_avail();
    pulse(1, 0, 0, 1, trig);
    for (int k = 0; k < 4; k++) begin
      expect_draw(1, trig, "p1_draw");
      if (k == 3) break;
      tick();
      pulse(1, 0, 1, 0, dummy);
      repeat (3) tick();
      available_card = rand_avail();
      pulse(1, 0, 0, 1, trig);
    end
    checks++;
    if (deal_count1 !== 5'd7 || my_turn1 !== 1'b1 || busy1 !== 1'b1) begin
      errors++;
      $display("FAIL p1_wait_ack_7: count=%0d my_turn=%b busy=%b, expected 7/1/1",
               deal_count1, my_turn1, busy1);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({deal_en1, deal_card1, msg1, deal_count1, my_turn1, busy1, done1, err1} !== c_rst_vec) begin
      errors++;
      $display("FAIL async_reset: got %h, expected %h",
               {deal_en1, deal_card1, msg1, deal_count1, my_turn1, busy1, done1, err1}, c_rst_vec);
    end
    tick();
    rst = 1'b1;
    pulse(1, 0, 1, 0, dummy);
    stray_en = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (deal_en1) stray_en = 1'b1;
    end
    checks++;
    if (stray_en || deal_count1 !== 5'd0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_ack: en=%b count=%0d busy=%b, expected 0/0/0",
               stray_en, deal_count1, busy1);
    end
  endtask

  initial begin
    seq[0] = 7'h5A;
    for (int i = 1; i < 127; i++) seq[i] = {seq[i-1][5:0], seq[i-1][6] ^ seq[i-1][5]};
    test_reset();
    test_full_deal();
    test_wrap();
    test_pulse_filter();
    test_error();
    test_player1_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached after %0d checks", checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
